// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, entry layout and the linear-address helper.
// Used by framebuffer_pixel_sink (optional build macro: PIXEL_SINK_CLIP_COUNT_EN).
package fb_pkg;

    localparam int SCREEN_W  = 320;
    localparam int SCREEN_H  = 240;
    localparam int FB_ADDR_W = 17;
    localparam int COLOR_W   = 3;
    localparam int X_W       = 9;
    localparam int Y_W       = 8;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [COLOR_W-1:0]   color;
    } fb_entry_t;

    // Row stride is 320 = 256 + 64, so the multiply reduces to two shifts and an add.
    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
        logic [FB_ADDR_W-1:0] xw;
        logic [FB_ADDR_W-1:0] yw;
        xw = FB_ADDR_W'(x);
        yw = FB_ADDR_W'(y);
        return (yw << 8) + (yw << 6) + xw;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module pixel_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: empty gating downstream hides stale contents.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/framebuffer_pixel_sink.sv
// Clips drawer pixel writes, converts them to framebuffer addresses and queues them
// for a granted memory port. PIXEL_SINK_CLIP_COUNT_EN adds a saturating clip counter.
module framebuffer_pixel_sink #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = fb_pkg::SCREEN_W,
    parameter int SCREEN_H = fb_pkg::SCREEN_H,
    parameter int ADDR_W   = fb_pkg::FB_ADDR_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              plot,
    input  logic [8:0]        xCoordinate,
    input  logic [7:0]        yCoordinate,
    input  logic [2:0]        colorToDraw,
    input  logic              mem_grant,
    input  logic              clear_overflow,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_data,
    output logic              fifo_full,
    output logic              almost_full,
    output logic              fifo_empty,
    output logic              overflow,
`ifdef PIXEL_SINK_CLIP_COUNT_EN
    output logic [15:0]       clip_count,
`endif
    output logic              busy
);

    import fb_pkg::*;

    localparam int          CW     = $clog2(DEPTH) + 1;
    localparam logic [8:0]  X_LIM  = 9'(SCREEN_W);
    localparam logic [7:0]  Y_LIM  = 8'(SCREEN_H);
    localparam logic [CW-1:0] AF_LVL = CW'(DEPTH - 2);

    logic          in_bounds;
    logic          s1_valid;
    fb_entry_t     s1_entry;
    fb_entry_t     head;
    logic          pop;
    logic [CW-1:0] count;

    assign in_bounds = (xCoordinate < X_LIM) && (yCoordinate < Y_LIM);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_entry <= '0;
        end else begin
            s1_valid <= plot && in_bounds;
            if (plot && in_bounds) begin
                s1_entry.addr  <= fb_addr(xCoordinate, yCoordinate);
                s1_entry.color <= colorToDraw;
            end
        end
    end

    pixel_fifo #(
        .WIDTH($bits(fb_entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock (clock),
        .resetn(resetn),
        .push  (s1_valid),
        .pop   (pop),
        .din   (s1_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign mem_we      = !fifo_empty;
    assign pop         = mem_we && mem_grant;
    assign mem_addr    = fifo_empty ? '0 : ADDR_W'(head.addr);
    assign mem_data    = fifo_empty ? '0 : head.color;
    assign almost_full = (count >= AF_LVL);
    assign busy        = s1_valid || !fifo_empty;

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clock) begin
        if (!resetn)                               overflow <= 1'b0;
        else if (s1_valid && fifo_full && !pop)    overflow <= 1'b1;
        else if (clear_overflow)                   overflow <= 1'b0;
    end

`ifdef PIXEL_SINK_CLIP_COUNT_EN
    always_ff @(posedge clock) begin
        if (!resetn)                                       clip_count <= '0;
        else if (clear_overflow)                           clip_count <= '0;
        else if (plot && !in_bounds && clip_count != 16'hFFFF) clip_count <= clip_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_framebuffer_pixel_sink.sv
// Directed bench for framebuffer_pixel_sink; build with PIXEL_SINK_CLIP_COUNT_EN to
// also cover the clip counter.
module tb_framebuffer_pixel_sink;

    logic        clock = 1'b0;
    logic        resetn;
    logic        plot;
    logic [8:0]  xCoordinate;
    logic [7:0]  yCoordinate;
    logic [2:0]  colorToDraw;
    logic        mem_grant;
    logic        clear_overflow;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [2:0]  mem_data;
    logic        fifo_full;
    logic        almost_full;
    logic        fifo_empty;
    logic        overflow;
    logic        busy;
`ifdef PIXEL_SINK_CLIP_COUNT_EN
    logic [15:0] clip_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    framebuffer_pixel_sink dut (
        .clock         (clock),
        .resetn        (resetn),
        .plot          (plot),
        .xCoordinate   (xCoordinate),
        .yCoordinate   (yCoordinate),
        .colorToDraw   (colorToDraw),
        .mem_grant     (mem_grant),
        .clear_overflow(clear_overflow),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .fifo_full     (fifo_full),
        .almost_full   (almost_full),
        .fifo_empty    (fifo_empty),
        .overflow      (overflow),
`ifdef PIXEL_SINK_CLIP_COUNT_EN
        .clip_count    (clip_count),
`endif
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic put(input int x, input int y, input int c);
        plot        = 1'b1;
        xCoordinate = 9'(x);
        yCoordinate = 8'(y);
        colorToDraw = 3'(c);
    endtask

    initial begin
        int n;
        int bad;
        int last;

        resetn = 1'b0; plot = 1'b0; xCoordinate = '0; yCoordinate = '0;
        colorToDraw = '0; mem_grant = 1'b0; clear_overflow = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);

        // single pixel: (5,2) -> 645, visible two edges after sampling
        mem_grant = 1'b1;
        put(5, 2, 6);
        tick();
        plot = 1'b0;
        chk("single_we_e0", mem_we, 0);
        chk("single_busy_e0", busy, 1);
        tick();
        chk("single_we_e1", mem_we, 1);
        chk("single_addr", mem_addr, 645);
        chk("single_data", mem_data, 6);
        tick();
        chk("single_we_after", mem_we, 0);
        chk("single_empty_after", fifo_empty, 1);
        chk("single_busy_after", busy, 0);

        // clipping
        put(320, 0, 1); tick();
        chk("clip_we_0", mem_we, 0);
        put(0, 240, 1); tick();
        chk("clip_we_1", mem_we, 0);
        plot = 1'b0;
        tick(); chk("clip_we_2", mem_we, 0);
        tick(); chk("clip_we_3", mem_we, 0);
        chk("clip_overflow", overflow, 0);
`ifdef PIXEL_SINK_CLIP_COUNT_EN
        chk("clip_count", clip_count, 2);
`endif

        // backpressure: 20 plots with no grant
        mem_grant = 1'b0;
        for (int i = 0; i < 20; i++) begin
            put(i, 0, i);
            tick();
        end
        plot = 1'b0;
        tick(); tick();
        chk("bp_full", fifo_full, 1);
        chk("bp_almost_full", almost_full, 1);
        chk("bp_overflow", overflow, 1);
        mem_grant = 1'b1;
        got_q.delete();
        for (int k = 0; k < 20; k++) begin
            if (mem_we) got_q.push_back(32'(mem_addr));
            tick();
        end
        chk("bp_write_count", got_q.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < got_q.size()) chk("bp_addr", got_q[k], k);
        end
        chk("bp_empty", fifo_empty, 1);
        chk("bp_overflow_sticky", overflow, 1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("ovf_cleared", overflow, 0);
`ifdef PIXEL_SINK_CLIP_COUNT_EN
        chk("clip_count_cleared", clip_count, 0);
`endif

        // full FIFO with simultaneous push and pop
        mem_grant = 1'b0;
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            put(100 + i, 1, 2);
            exp_q.push_back(32'(320 + 100 + i));
            tick();
        end
        plot = 1'b0;
        tick(); tick();
        chk("pp_full_before", fifo_full, 1);
        put(200, 1, 5);
        exp_q.push_back(32'(520));
        tick();
        for (int i = 1; i <= 10; i++) begin
            mem_grant = 1'b1;
            if (mem_we) got_q.push_back(32'(mem_addr));
            put(200 + i, 1, 5);
            exp_q.push_back(32'(520 + i));
            tick();
            chk("pp_full_hold", fifo_full, 1);
            chk("pp_no_overflow", overflow, 0);
        end
        plot = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (mem_we) got_q.push_back(32'(mem_addr));
            tick();
        end
        chk("pp_write_count", got_q.size(), exp_q.size());
        bad = 0;
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
            if (got_q[k] !== exp_q[k]) bad++;
        chk("pp_order", bad, 0);

        // full-screen raster sweep at full rate
        mem_grant = 1'b1;
        n = 0; bad = 0; last = -1;
        for (int y = 0; y < 240; y++) begin
            for (int x = 0; x < 320; x++) begin
                if (mem_we) begin
                    if (32'(mem_addr) !== 32'(n)) bad++;
                    last = int'(mem_addr);
                    n++;
                end
                put(x, y, x);
                tick();
            end
        end
        plot = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (mem_we) begin
                if (32'(mem_addr) !== 32'(n)) bad++;
                last = int'(mem_addr);
                n++;
            end
            tick();
        end
        chk("sweep_count", n, 76800);
        chk("sweep_order", bad, 0);
        chk("sweep_last", last, 76799);
        chk("sweep_overflow", overflow, 0);

        // reset mid-stream with 5 buffered entries
        mem_grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            put(i, 3, 1);
            tick();
        end
        plot = 1'b0;
        tick(); tick();
        chk("mid_we_before", mem_we, 1);
        chk("mid_full_before", fifo_full, 0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("mid_we_after", mem_we, 0);
        chk("mid_empty_after", fifo_empty, 1);
        chk("mid_busy_after", busy, 0);
        mem_grant = 1'b1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (mem_we) n++;
            tick();
        end
        chk("mid_no_stale", n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
